slot_capture_bank: RTL and testbench

//   Clocked, parametrised bank of DEPTH data slots, each WIDTH bits wide, loaded from a single write port.

---
 rtl/slot_capture_bank.sv | 77 +++++++
 tb/tb_slot_capture_bank.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/slot_capture_bank.sv
// rtl/slot_capture_bank.sv - parametrised slot bank with auto-capture pointer, valid flags and registered read
module slot_capture_bank #(
  parameter  int WIDTH = 11,
  parameter  int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic                   wr_auto,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clear,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [WIDTH-1:0]       rd_data,
  output logic [WIDTH*DEPTH-1:0] slots_flat,
  output logic [DEPTH-1:0]       slot_valid,
  output logic [IDX_W-1:0]       wr_ptr,
  output logic                   frame_done
);

  // One extra bit so the range checks also work when DEPTH is a power of two.
  localparam logic [IDX_W:0]   DEPTH_EXT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] target;
  logic             target_ok;
  logic             wr_en;
  logic             auto_en;
  logic             rd_ok;

  always_comb begin
    target    = wr_auto ? wr_ptr : wr_idx;
    target_ok = ({1'b0, target} < DEPTH_EXT);
    wr_en     = wr_valid && !clear && target_ok;
    auto_en   = wr_valid && !clear && wr_auto;
    rd_ok     = ({1'b0, rd_idx} < DEPTH_EXT);
  end

  always_comb begin
    slots_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slots_flat[i*WIDTH +: WIDTH] = mem[i];
    end
  end

  // Read samples mem before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      slot_valid <= '0;
      wr_ptr     <= '0;
      rd_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      rd_data <= rd_ok ? mem[rd_idx] : '0;
      if (clear) begin
        slot_valid <= '0;
        wr_ptr     <= '0;
        frame_done <= 1'b0;
      end else begin
        if (wr_en) begin
          mem[target]        <= wr_data;
          slot_valid[target] <= 1'b1;
        end
        if (auto_en) begin
          wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + IDX_W'(1);
        end
        frame_done <= auto_en && (wr_ptr == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_slot_capture_bank.sv
// tb/tb_slot_capture_bank.sv - scoreboard bench for slot_capture_bank, DEPTH=64 and DEPTH=40 side by side
module tb_slot_capture_bank;

  localparam int W  = 11;
  localparam int FW = 64 * W;

  typedef struct {
    logic [FW-1:0] flat;
    logic [63:0]   valid;
    int            ptr;
    int            rd;
    bit            fd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, wr_valid, wr_auto, clear;
  logic [5:0]    wr_idx, rd_idx;
  logic [W-1:0]  wr_data;

  logic [W-1:0]  a_rd, b_rd;
  logic [64*W-1:0] a_flat;
  logic [40*W-1:0] b_flat;
  logic [63:0]   a_valid;
  logic [39:0]   b_valid;
  logic [5:0]    a_ptr, b_ptr;
  logic          a_fd, b_fd;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  // Reference state: [0] models the 64-slot build, [1] the 40-slot build.
  int   mm[2][64];
  bit   mv[2][64];
  int   mp[2];

  slot_capture_bank #(.WIDTH(W), .DEPTH(64)) dut64 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_auto(wr_auto), .wr_idx(wr_idx),
    .wr_data(wr_data), .clear(clear), .rd_idx(rd_idx), .rd_data(a_rd),
    .slots_flat(a_flat), .slot_valid(a_valid), .wr_ptr(a_ptr), .frame_done(a_fd)
  );

  slot_capture_bank #(.WIDTH(W), .DEPTH(40)) dut40 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_auto(wr_auto), .wr_idx(wr_idx),
    .wr_data(wr_data), .clear(clear), .rd_idx(rd_idx), .rd_data(b_rd),
    .slots_flat(b_flat), .slot_valid(b_valid), .wr_ptr(b_ptr), .frame_done(b_fd)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [FW-1:0] act, logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model_step(int k, bit r, bit wv, bit wa, int wi, int wd, bit cl, int ri);
    int   dep = (k == 0) ? 64 : 40;
    int   t;
    exp_t e;
    e.rd = (ri < dep) ? mm[k][ri] : 0;
    e.fd = 1'b0;
    if (r) begin
      for (int i = 0; i < 64; i++) begin
        mm[k][i] = 0;
        mv[k][i] = 1'b0;
      end
      mp[k] = 0;
      e.rd  = 0;
    end else if (cl) begin
      for (int i = 0; i < 64; i++) mv[k][i] = 1'b0;
      mp[k] = 0;
    end else if (wv) begin
      t = wa ? mp[k] : wi;
      if (t < dep) begin
        mm[k][t] = wd;
        mv[k][t] = 1'b1;
      end
      if (wa) begin
        e.fd  = (t == dep - 1);
        mp[k] = (mp[k] + 1) % dep;
      end
    end
    e.flat  = '0;
    e.valid = '0;
    for (int i = 0; i < dep; i++) begin
      e.flat[i*W +: W] = W'(mm[k][i]);
      e.valid[i]       = mv[k][i];
    end
    e.ptr = mp[k];
    return e;
  endfunction

  task automatic cyc(bit r, bit wv, bit wa, int wi, int wd, bit cl, int ri);
    rst      = r;
    wr_valid = wv;
    wr_auto  = wa;
    wr_idx   = 6'(wi);
    wr_data  = W'(wd);
    clear    = cl;
    rd_idx   = 6'(ri);
    qa.push_back(model_step(0, r, wv, wa, wi, wd & 'h7FF, cl, ri));
    qb.push_back(model_step(1, r, wv, wa, wi, wd & 'h7FF, cl, ri));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("d64.slots_flat", FW'(a_flat), e.flat);
      chk("d64.slot_valid", FW'(a_valid), FW'(e.valid));
      chk("d64.wr_ptr", FW'(a_ptr), FW'(e.ptr));
      chk("d64.rd_data", FW'(a_rd), FW'(e.rd));
      chk("d64.frame_done", FW'(a_fd), FW'(e.fd));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("d40.slots_flat", FW'(b_flat), e.flat);
      chk("d40.slot_valid", FW'(b_valid), FW'(e.valid));
      chk("d40.wr_ptr", FW'(b_ptr), FW'(e.ptr));
      chk("d40.rd_data", FW'(b_rd), FW'(e.rd));
      chk("d40.frame_done", FW'(b_fd), FW'(e.fd));
    end
  end

  initial begin
    // reset held two cycles
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // manual writes, top slot and out-of-range for the 40-slot build
    cyc(0, 1, 0, 5, 'h155, 0, 0);
    cyc(0, 1, 0, 63, 'h7FF, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 63);
    cyc(0, 1, 0, 45, 'h2AB, 0, 45);
    cyc(0, 0, 0, 0, 0, 0, 45);
    cyc(0, 0, 0, 0, 0, 0, 5);

    // full auto frame, wrap, and overwrite of slot 0
    for (int i = 0; i < 64; i++) cyc(0, 1, 1, 0, i, 0, i);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 'h0AA, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // clear beats a same-cycle auto write at pointer 10
    cyc(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 'h300 + i, 0, 0);
    cyc(0, 1, 1, 0, 'h5A5, 1, 10);
    cyc(0, 0, 0, 0, 0, 0, 10);

    // read-before-write on the same slot
    cyc(0, 1, 0, 7, 'h001, 0, 0);
    cyc(0, 1, 0, 7, 'h123, 0, 7);
    cyc(0, 0, 0, 0, 0, 0, 7);
    cyc(0, 0, 0, 0, 0, 0, 7);

    // reset in the middle of an auto frame
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0, 'h400 + i, 0, i);
    cyc(1, 1, 1, 0, 'h7AA, 0, 3);
    cyc(0, 0, 0, 0, 0, 0, 3);

    // randomized traffic, biased toward auto bursts so frames complete
    for (int n = 0; n < 1500; n++) begin
      bit r  = ($urandom_range(0, 199) == 0);
      bit cl = ($urandom_range(0, 39) == 0);
      bit wv = ($urandom_range(0, 3) != 0);
      bit wa = ($urandom_range(0, 4) != 0);
      cyc(r, wv, wa, $urandom_range(0, 63), $urandom_range(0, 2047), cl, $urandom_range(0, 63));
    end
    cyc(0, 0, 0, 0, 0, 0, 0);

    repeat (4) @(negedge clk);
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
